// File: rtl/div_unit.sv
// div_unit: 32-bit iterative restoring divider (DIV/DIVU/REM/REMU), result 33 edges after acceptance.
// Optional macro DIV_UNIT_SIGNED_EN adds signed DIV/REM; without it DIV/REM execute as DIVU/REMU.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  f,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] quo;       // dividend magnitude shifting out, quotient bits shifting in
    logic [31:0] rem;
    logic [31:0] dvs;       // divisor magnitude; zero iff b was zero
    logic [31:0] dividend;  // original a, returned as the remainder of a divide by zero
    logic        op_valid;
    logic        op_rem;
`ifdef DIV_UNIT_SIGNED_EN
    logic        neg_q;
    logic        neg_r;
    logic        req_signed;
`endif

    logic        req_valid;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] q_fix;
    logic [31:0] r_fix;
    logic [31:0] result;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        req_valid = (f[4:2] == 3'b101);
`ifdef DIV_UNIT_SIGNED_EN
        req_signed = req_valid && !f[0];
        a_mag      = (req_signed && a[31]) ? -a : a;
        b_mag      = (req_signed && b[31]) ? -b : b;
`else
        a_mag      = a;
        b_mag      = b;
`endif
    end

    // One restoring step: a clear borrow bit means the shifted remainder covers the divisor.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
    end

    always_comb begin
`ifdef DIV_UNIT_SIGNED_EN
        q_fix = neg_q ? -quo : quo;
        r_fix = neg_r ? -rem : rem;
`else
        q_fix = quo;
        r_fix = rem;
`endif
        if (!op_valid)
            result = 32'd0;
        else if (dvs == 32'd0)
            result = op_rem ? dividend : 32'hFFFF_FFFF;
        else
            result = op_rem ? r_fix : q_fix;
    end

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            y         <= 32'd0;
            cnt       <= 6'd0;
            quo       <= 32'd0;
            rem       <= 32'd0;
            dvs       <= 32'd0;
            dividend  <= 32'd0;
            op_valid  <= 1'b0;
            op_rem    <= 1'b0;
`ifdef DIV_UNIT_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        quo      <= a_mag;
                        rem      <= 32'd0;
                        dvs      <= b_mag;
                        dividend <= a;
                        op_valid <= req_valid;
                        op_rem   <= f[1];
`ifdef DIV_UNIT_SIGNED_EN
                        neg_q    <= req_signed && (a[31] ^ b[31]);
                        neg_r    <= req_signed && a[31];
`endif
                        cnt      <= 6'd0;
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    // 32 division steps, then one cycle to apply sign and special-case fixups.
                    if (cnt == 6'd32) begin
                        y         <= result;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        if (!diff[32]) begin
                            rem <= diff[31:0];
                            quo <= {quo[30:0], 1'b1};
                        end else begin
                            rem <= shifted[31:0];
                            quo <= {quo[30:0], 1'b0};
                        end
                        cnt <= cnt + 6'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        y         <= 32'd0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    y         <= 32'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard queue of expected results, latency and handshake checks.
// Expectations follow DIV_UNIT_SIGNED_EN when it is defined for the bench as well.
module tb_div_unit;
    localparam logic [4:0] F_DIV  = 5'b10100;
    localparam logic [4:0] F_DIVU = 5'b10101;
    localparam logic [4:0] F_REM  = 5'b10110;
    localparam logic [4:0] F_REMU = 5'b10111;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  f;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    div_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .f         (f),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model built on the language's own division operators.
    function automatic logic [31:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [4:0] mf);
        logic is_signed;
        if (mf[4:2] != 3'b101) return 32'd0;
`ifdef DIV_UNIT_SIGNED_EN
        is_signed = !mf[0];
`else
        is_signed = 1'b0;
`endif
        if (mb == 32'd0) return mf[1] ? ma : 32'hFFFF_FFFF;
        if (is_signed) begin
            if (ma == 32'h8000_0000 && mb == 32'hFFFF_FFFF) return mf[1] ? 32'd0 : 32'h8000_0000;
            return mf[1] ? 32'($signed(ma) % $signed(mb)) : 32'($signed(ma) / $signed(mb));
        end
        return mf[1] ? ma % mb : ma / mb;
    endfunction

    task automatic issue_op(input logic [31:0] oa, input logic [31:0] ob, input logic [4:0] of_, input logic [31:0] oe);
        int waited;
        waited = 0;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        a = oa; b = ob; f = of_; in_valid = 1'b1;
        exp_q.push_back(oe);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; f = 5'($urandom);
    endtask

    // Called one #1 after the accepting edge; counts edges until out_valid.
    task automatic finish_op(input string name, input bit consume);
        int          edges;
        bit          busy_err;
        logic [31:0] e;
        edges = 0;
        busy_err = 1'b0;
        while (out_valid !== 1'b1 && edges < 60) begin
            if (y !== 32'd0 || in_ready !== 1'b0) busy_err = 1'b1;
            @(posedge clk); #1;
            edges++;
        end
        checks++;
        if (edges != 33) begin
            errors++;
            $display("FAIL %s_latency: edges=%0d required 33", name, edges);
        end
        checks++;
        if (busy_err) begin
            errors++;
            $display("FAIL %s_busy: y nonzero or in_ready high while computing (got 1 required 0)", name);
        end
        e = exp_q.pop_front();
        checks++;
        if (y !== e) begin
            errors++;
            $display("FAIL %s: y=%h required %h", name, y, e);
        end
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s_release: out_valid=%b y=%h in_ready=%b required 0 0 1", name, out_valid, y, in_ready);
            end
        end
    endtask

    task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input logic [4:0] of_, input logic [31:0] oe, input string name);
        issue_op(oa, ob, of_, oe);
        finish_op(name, 1'b1);
    endtask

    task automatic expect_idle(input string name);
        checks++;
        if (out_valid !== 1'b0 || y !== 32'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: out_valid=%b y=%h in_ready=%b required 0 0 1", name, out_valid, y, in_ready);
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL %s: out_valid rose (got 1 required 0)", name);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 32'd0; b = 32'd0; f = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        expect_idle("reset_held");
        rst_n = 1'b1;
        @(posedge clk); #1;
        expect_idle("reset_released");
    endtask

    task automatic test_unsigned();
        do_op(32'd100, 32'd7, F_DIVU, 32'd14, "divu_100_7");
        do_op(32'd100, 32'd7, F_REMU, 32'd2, "remu_100_7");
        do_op(32'hFFFF_FFFF, 32'd1, F_DIVU, 32'hFFFF_FFFF, "divu_max_1");
        do_op(32'd3, 32'd10, F_REMU, 32'd3, "remu_small");
        do_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, F_DIVU, 32'd0, "divu_a_lt_b");
    endtask

    task automatic test_signed();
`ifdef DIV_UNIT_SIGNED_EN
        do_op(32'hFFFF_FFF9, 32'd2, F_DIV, 32'hFFFF_FFFD, "div_m7_2");
        do_op(32'hFFFF_FFF9, 32'd2, F_REM, 32'hFFFF_FFFF, "rem_m7_2");
        do_op(32'd7, 32'hFFFF_FFFE, F_REM, 32'd1, "rem_7_m2");
`else
        do_op(32'hFFFF_FFF9, 32'd2, F_DIV, 32'h7FFF_FFFC, "div_m7_2");
        do_op(32'hFFFF_FFF9, 32'd2, F_REM, 32'd1, "rem_m7_2");
        do_op(32'd7, 32'hFFFF_FFFE, F_REM, 32'd7, "rem_7_m2");
`endif
        do_op(32'hFFFF_FF9C, 32'd7, F_DIV, model(32'hFFFF_FF9C, 32'd7, F_DIV), "div_m100_7");
        do_op(32'hFFFF_FF9C, 32'hFFFF_FFF9, F_REM, model(32'hFFFF_FF9C, 32'hFFFF_FFF9, F_REM), "rem_m100_m7");
    endtask

    task automatic test_special();
        do_op(32'd5, 32'd0, F_DIVU, 32'hFFFF_FFFF, "divu_by_zero");
        do_op(32'd5, 32'd0, F_DIV, 32'hFFFF_FFFF, "div_by_zero");
        do_op(32'd5, 32'd0, F_REM, 32'd5, "rem_by_zero");
        do_op(32'd5, 32'd0, F_REMU, 32'd5, "remu_by_zero");
        do_op(32'hFFFF_FFF9, 32'd0, F_DIV, 32'hFFFF_FFFF, "div_neg_by_zero");
        do_op(32'hFFFF_FFF9, 32'd0, F_REM, 32'hFFFF_FFF9, "rem_neg_by_zero");
`ifdef DIV_UNIT_SIGNED_EN
        do_op(32'h8000_0000, 32'hFFFF_FFFF, F_DIV, 32'h8000_0000, "div_overflow");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, F_REM, 32'd0, "rem_overflow");
`else
        do_op(32'h8000_0000, 32'hFFFF_FFFF, F_DIV, 32'd0, "div_overflow");
        do_op(32'h8000_0000, 32'hFFFF_FFFF, F_REM, 32'h8000_0000, "rem_overflow");
`endif
    endtask

    task automatic test_invalid_f();
        do_op(32'd100, 32'd7, 5'b00000, 32'd0, "bad_f_00000");
        do_op(32'd100, 32'd0, 5'b10000, 32'd0, "bad_f_10000");
        do_op(32'hFFFF_FFFF, 32'd3, 5'b11101, 32'd0, "bad_f_11101");
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        bit          ok;
        issue_op(32'd1234, 32'd10, F_REMU, 32'd4);
        finish_op("bp_result", 1'b0);
        held = y;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a = 32'd9; b = 32'd3; f = F_DIVU; in_valid = 1'b1;
            end
            @(posedge clk); #1;
            ok = (out_valid === 1'b1) && (y === held) && (in_ready === 1'b0);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL bp_hold_%0d: out_valid=%b y=%h in_ready=%b required 1 %h 0", i, out_valid, y, in_ready, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        expect_idle("bp_exit");
        exp_q.push_back(32'd3);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_next_accept: in_ready=%b required 0", in_ready);
        end
        finish_op("bp_next", 1'b1);
    endtask

    task automatic test_reset_mid();
        issue_op(32'd1000, 32'd3, F_DIVU, 32'd333);
        repeat (15) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(exp_q.pop_back());
        expect_idle("rst_mid_calc");
        expect_quiet("rst_mid_calc_quiet", 40);
        do_op(32'd9, 32'd3, F_DIVU, 32'd3, "after_rst_divu_9_3");

        issue_op(32'd50, 32'd5, F_DIVU, 32'd10);
        finish_op("done_before_rst", 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_idle("rst_mid_done");

        a = 32'd9; b = 32'd3; f = F_DIVU; in_valid = 1'b1; rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        expect_idle("rst_vs_handshake");
        expect_quiet("rst_vs_handshake_quiet", 40);
        do_op(32'd77, 32'd11, F_DIVU, 32'd7, "after_rst_divu_77_11");
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rf;
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 4 == 1) rb = rb >> 20;
            rf = {3'b101, 2'($urandom)};
            do_op(ra, rb, rf, model(ra, rb, rf), "rand_op");
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_invalid_f();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: request offered.
REQ-004 SHALL have port in_ready, output, 1 bit: request accepted when in_valid and in_ready are both high at a rising edge.
REQ-005 SHALL have port a, input, 32 bits: dividend.
REQ-006 SHALL have port b, input, 32 bits: divisor.
REQ-007 SHALL have port f, input, 5 bits: operation select, same width as the ALU function code. 5'b10100 selects DIV, 5'b10101 DIVU, 5'b10110 REM, 5'b10111 REMU.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes the result when out_valid and out_ready are both high at an edge.
REQ-010 SHALL have port y, output, 32 bits: quotient or remainder.

Function
REQ-011 SHALL implement the states IDLE, CALC and DONE; in_ready SHALL be high only in IDLE, and out_valid SHALL be high only in DONE.
REQ-012 SHALL, on acceptance, register a, b and f and move IDLE->CALC; the request input ports SHALL be ignored at all other times.
REQ-013 SHALL, in CALC, perform one restoring-division step per cycle on 32-bit magnitudes for exactly 32 cycles, then move to DONE.
REQ-014 SHALL assert out_valid exactly 33 rising edges after the accepting edge, for every operand value, including the special cases.
REQ-015 SHALL hold y and out_valid stable in DONE while out_ready is low, and SHALL move DONE->IDLE on the edge where out_ready is high.
REQ-016 SHALL NOT accept a new request in the DONE-exit cycle; in_ready SHALL rise in the following cycle, giving no same-cycle turnaround.
REQ-017 SHALL, for DIV and REM, divide the magnitudes, negate the quotient when the operand signs differ, and give the remainder the sign of the dividend.
REQ-018 SHALL, for DIVU and REMU, treat the operands as unsigned.
REQ-019 SHALL, for divide by zero (b==0), give a quotient of 32'hFFFFFFFF and a remainder equal to a, for both signed and unsigned operations.
REQ-020 SHALL, for signed overflow (a==32'h80000000 and b==32'hFFFFFFFF under DIV/REM), give a quotient of 32'h80000000 and a remainder of 0.
REQ-021 SHALL, for any f other than the four listed codes, accept the request, take the normal latency, and return y=0.
REQ-022 SHALL keep y at 0 whenever out_valid is low.

Reset
REQ-023 SHALL, when rst_n is low at an edge, enter IDLE with in_ready=1, out_valid=0, y=0, and all datapath registers cleared.
REQ-024 SHALL, on reset asserted mid-CALC or mid-DONE, abandon the operation with no result delivered; the first request after reset SHALL complete normally.
REQ-025 SHALL override a simultaneous handshake with reset, so no request is accepted on a reset edge.

Configuration
REQ-026 SHALL, with the macro DIV_UNIT_SIGNED_EN defined, implement signed DIV/REM as specified in REQ-017 and REQ-020.
REQ-027 SHALL, without DIV_UNIT_SIGNED_EN, have no sign-correction logic, execute DIV as DIVU and REM as REMU, and leave latency and handshake unchanged.

Verification
REQ-028 SHALL cover: DIVU a=100, b=7 -> y=14 at out_valid, 33 edges after acceptance; REMU with the same operands -> y=2.
REQ-029 SHALL cover: DIV a=-7 (32'hFFFFFFF9), b=2 -> y=32'hFFFFFFFD; REM -> y=32'hFFFFFFFF (signed build); the unsigned build gives DIVU results.
REQ-030 SHALL cover: DIV or DIVU with b=0, a=5 -> y=32'hFFFFFFFF; REM with b=0 -> y=5.
REQ-031 SHALL cover: DIV a=32'h80000000, b=32'hFFFFFFFF -> y=32'h80000000; REM -> y=0.
REQ-032 SHALL cover: out_ready held low for 10 cycles in DONE -> y and out_valid stable, in_ready=0, and a new in_valid is ignored; release -> IDLE, next request accepted one cycle later.
REQ-033 SHALL cover: rst_n low at CALC cycle 16 -> the next cycle shows out_valid=0, in_ready=1 and y=0; a following DIVU 9/3 -> y=3.
